pipe_mem_stall_ctrl: RTL and testbench

// - Pipeline sequencer for the 5-stage CPU. Issues one IM fetch and, when MEM holds a load/store, one DM access per step.
// - Holds all pipeline registers (stall_CPU) until every issued access completes, then releases them for exactly one advance cycle.
// - In the advance cycle, applies the load-use bubble and the branch flush.
// - Sits between the CPU pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the IM/DM bus wrappers.

---
 rtl/pipe_mem_stall_ctrl_if.sv | 41 ++++
 rtl/pipe_mem_stall_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_mem_stall_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_stall_ctrl_if.sv
// Bus bundle between the pipeline stall sequencer and its neighbours:
// the CPU pipeline registers and the IM/DM bus wrappers.
//
// Handshake: im_req/dm_req are 1-cycle start pulses from the sequencer.
// Each wrapper answers with one 1-cycle im_done/dm_done pulse when its access
// completes. There is no ready back-pressure on req. A done that arrives
// while no access is pending is ignored by the sequencer.
//
// The master modport is the sequencer; slave is the pipeline/wrapper side.
interface pipe_mem_stall_ctrl_if;
   logic [2:0] ex_mem_memread;
   logic [2:0] ex_mem_memwrite;
   logic [2:0] id_ex_memread;
   logic [4:0] id_ex_rd;
   logic [4:0] if_id_rs1;
   logic [4:0] if_id_rs2;
   logic       branch_taken;
   logic       im_done;
   logic       dm_done;
   logic       im_req;
   logic       dm_req;
   logic       stall_CPU;
   logic       pc_write;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       bus_timeout;

   modport master (
      input  ex_mem_memread, ex_mem_memwrite, id_ex_memread, id_ex_rd,
             if_id_rs1, if_id_rs2, branch_taken, im_done, dm_done,
      output im_req, dm_req, stall_CPU, pc_write, if_id_flush,
             id_ex_bubble, bus_timeout
   );

   modport slave (
      output ex_mem_memread, ex_mem_memwrite, id_ex_memread, id_ex_rd,
             if_id_rs1, if_id_rs2, branch_taken, im_done, dm_done,
      input  im_req, dm_req, stall_CPU, pc_write, if_id_flush,
             id_ex_bubble, bus_timeout
   );
endinterface

// File: rtl/pipe_mem_stall_ctrl.sv
// Pipeline sequencer for the 5-stage CPU.
// Each step: issue an IM fetch (plus a DM access when MEM holds a load/store),
// hold the whole pipeline until every issued access has completed, then
// release it for exactly one advance cycle in which the branch flush and the
// load-use bubble are applied.
//
// Optional feature macro: STALL_PERF_EN adds the perf_stall_cyc and
// perf_bubble_cnt counter outputs (CNT_W bits, wrapping).
module pipe_mem_stall_ctrl #(
   parameter int WAIT_LIMIT = 1024,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_mem_stall_ctrl_if.master bus,
   output logic [1:0]            dbg_state_o
`ifdef STALL_PERF_EN
   ,
   output logic [CNT_W-1:0]      perf_stall_cyc,
   output logic [CNT_W-1:0]      perf_bubble_cnt
`endif
);

   // Counter wide enough to hold WAIT_LIMIT itself (it saturates there).
   localparam int WCW = $clog2(WAIT_LIMIT + 1);
   localparam logic [WCW-1:0] WLIM = WCW'(WAIT_LIMIT);

   // Elaboration-time guard against unusable parameter values.
   if ((WAIT_LIMIT < 2) || (CNT_W < 1)) begin : g_bad_params
      $error("pipe_mem_stall_ctrl: WAIT_LIMIT must be >= 2 and CNT_W >= 1");
   end

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_ADV   = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic           im_pend_q, im_pend_d;
   logic           dm_pend_q, dm_pend_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic [WCW-1:0] wait_inc;
   logic           timeout_q, timeout_d;

   logic           mem_op;
   logic           load_use;
   logic           im_req, dm_req, stall, pc_write, flush, bubble;

   assign mem_op   = |(bus.ex_mem_memread | bus.ex_mem_memwrite);
   assign load_use = (|bus.id_ex_memread) && (|bus.id_ex_rd) &&
                     ((bus.id_ex_rd == bus.if_id_rs1) ||
                      (bus.id_ex_rd == bus.if_id_rs2));
   // Saturating increment of the wait counter.
   assign wait_inc = (wait_cnt_q == WLIM) ? wait_cnt_q : wait_cnt_q + WCW'(1);

   // State, pending flags and sticky timeout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_ISSUE;
         im_pend_q  <= 1'b0;
         dm_pend_q  <= 1'b0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         im_pend_q  <= im_pend_d;
         dm_pend_q  <= dm_pend_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state and output decode. Done pulses only affect the pending flags,
   // so stall/pc_write never depend combinationally on im_done/dm_done.
   always_comb begin
      state_d    = state_q;
      im_pend_d  = im_pend_q;
      dm_pend_d  = dm_pend_q;
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      im_req     = 1'b0;
      dm_req     = 1'b0;
      stall      = 1'b1;
      pc_write   = 1'b0;
      flush      = 1'b0;
      bubble     = 1'b0;

      case (state_q)
         S_ISSUE: begin
            // Dones seen here belong to nothing we issued yet: not sampled.
            im_req    = 1'b1;
            dm_req    = mem_op;
            im_pend_d = 1'b1;
            dm_pend_d = mem_op;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            im_pend_d  = im_pend_q & ~bus.im_done;
            dm_pend_d  = dm_pend_q & ~bus.dm_done;
            wait_cnt_d = wait_inc;
            if (wait_inc == WLIM) begin
               timeout_d = 1'b1;
            end
            if (!im_pend_d && !dm_pend_d) begin
               state_d    = S_ADV;
               wait_cnt_d = '0;
            end
         end
         S_ADV: begin
            stall     = 1'b0;
            im_pend_d = 1'b0;
            dm_pend_d = 1'b0;
            state_d   = S_ISSUE;
            if (bus.branch_taken) begin
               // Redirect to the branch target and squash both younger slots.
               pc_write = 1'b1;
               flush    = 1'b1;
               bubble   = 1'b1;
            end else if (load_use) begin
               // Hold PC and IF/ID, let a NOP flow into EX.
               bubble = 1'b1;
            end else begin
               pc_write = 1'b1;
            end
         end
         default: begin
            state_d   = S_ISSUE;
            im_pend_d = 1'b0;
            dm_pend_d = 1'b0;
         end
      endcase

      // The reset cycle presents a frozen, request-free pipeline.
      if (rst) begin
         im_req   = 1'b0;
         dm_req   = 1'b0;
         stall    = 1'b1;
         pc_write = 1'b0;
         flush    = 1'b0;
         bubble   = 1'b0;
      end
   end

   assign bus.im_req       = im_req;
   assign bus.dm_req       = dm_req;
   assign bus.stall_CPU    = stall;
   assign bus.pc_write     = pc_write;
   assign bus.if_id_flush  = flush;
   assign bus.id_ex_bubble = bubble;
   assign bus.bus_timeout  = timeout_q;
   assign dbg_state_o      = state_q;

`ifdef STALL_PERF_EN
   logic [CNT_W-1:0] stall_cyc_q;
   logic [CNT_W-1:0] bubble_cnt_q;

   // Performance counters: stalled cycles and advance cycles that bubbled.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cyc_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (stall) begin
            stall_cyc_q <= stall_cyc_q + CNT_W'(1);
         end
         if ((state_q == S_ADV) && bubble) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         end
      end
   end

   assign perf_stall_cyc  = stall_cyc_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_mem_stall_ctrl.sv
// Bench for pipe_mem_stall_ctrl. One "step" = issue, wait, advance; the
// reference model derives every expected output of a step from its wait
// length and the hazard/branch inputs applied in the advance cycle.
module tb_pipe_mem_stall_ctrl;
  localparam int WAIT_LIMIT = 4;
  localparam int CNT_W      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] perf_stall_cyc;
  logic [CNT_W-1:0] perf_bubble_cnt;
`endif

  pipe_mem_stall_ctrl_if bus ();

  pipe_mem_stall_ctrl #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .dbg_state_o(dbg_state)
`ifdef STALL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_bad    = 0;
  logic [6:0] exp_q[$];
  bit         sticky_tmo = 1'b0;
  int         mdl_stall_cyc = 0;
  int         mdl_bubbles   = 0;
  bit [3:0]   seen_states = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs_vec();
    return {bus.im_req, bus.dm_req, bus.stall_CPU, bus.pc_write,
            bus.if_id_flush, bus.id_ex_bubble, bus.bus_timeout};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_pipe_inputs();
    bus.id_ex_memread = 3'($urandom_range(0, 7));
    bus.id_ex_rd      = 5'($urandom_range(0, 3));
    bus.if_id_rs1     = 5'($urandom_range(0, 3));
    bus.if_id_rs2     = 5'($urandom_range(0, 3));
    bus.branch_taken  = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_cycle();
`ifdef STALL_PERF_EN
    check_val("perf_stall_cyc", 32'(perf_stall_cyc), 32'(CNT_W'(mdl_stall_cyc)));
    check_val("perf_bubble_cnt", 32'(perf_bubble_cnt), 32'(CNT_W'(mdl_bubbles)));
`endif
    seen_states[dbg_state] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    bus.im_done = 1'b0;
    bus.dm_done = 1'b0;
    @(negedge clk);
    // Timeout/counter registers clear at the edge, so only the decoded outputs are checked here.
    check_val(tag, 32'(obs_vec() >> 1), 32'(6'b001000));
    finish_cycle();
    sticky_tmo    = 1'b0;
    mdl_stall_cyc = 0;
    mdl_bubbles   = 0;
  endtask

  // One pipeline step. di/dd: S_WAIT cycle index (0-based) of im_done/dm_done.
  // rst_at >= 0 aborts the step with a reset in that S_WAIT cycle.
  task automatic do_step(input bit mem, input int di, input int dd,
                         input logic [2:0] id_mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit br, input int rst_at);
    int         len;
    int         k;
    int         waits_done;
    bit         haz;
    bit         tmo;
    logic [6:0] e;
    logic [6:0] got;
    len = ((mem && (dd > di)) ? dd : di) + 1;
    haz = (id_mr != 3'd0) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    for (int c = 0; c <= len + 1; c++) begin
      if ((rst_at >= 0) && (c == rst_at + 1)) begin
        reset_cycle("rst_mid_wait");
        rst = 1'b0;
        return;
      end
      rst = 1'b0;
      rand_pipe_inputs();
      bus.im_done = 1'b0;
      bus.dm_done = 1'b0;
      if (c == 0) begin
        if (mem) begin
          bus.ex_mem_memread  = 3'($urandom_range(0, 7));
          bus.ex_mem_memwrite = (bus.ex_mem_memread == 3'd0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end else begin
          bus.ex_mem_memread  = 3'd0;
          bus.ex_mem_memwrite = 3'd0;
        end
        // Dones in the issue cycle must be ignored.
        bus.im_done = 1'($urandom_range(0, 1));
        bus.dm_done = 1'($urandom_range(0, 1));
      end else begin
        bus.ex_mem_memread  = 3'($urandom_range(0, 7));
        bus.ex_mem_memwrite = 3'($urandom_range(0, 7));
        if (c <= len) begin
          k = c - 1;
          bus.im_done = (k == di) || ((k > di) && ($urandom_range(0, 3) == 0));
          if (mem) bus.dm_done = (k == dd) || ((k > dd) && ($urandom_range(0, 3) == 0));
          else     bus.dm_done = ($urandom_range(0, 3) == 0);
        end else begin
          bus.im_done       = 1'($urandom_range(0, 1));
          bus.dm_done       = 1'($urandom_range(0, 1));
          bus.id_ex_memread = id_mr;
          bus.id_ex_rd      = rd;
          bus.if_id_rs1     = rs1;
          bus.if_id_rs2     = rs2;
          bus.branch_taken  = br;
        end
      end
      // Reference: timeout is visible once WAIT_LIMIT wait cycles have completed.
      waits_done = (c == 0) ? 0 : (((c - 1) < len) ? (c - 1) : len);
      tmo = sticky_tmo || (waits_done >= WAIT_LIMIT);
      if (c == 0)        e = {1'b1, mem, 1'b1, 4'b0000};
      else if (c <= len) e = {3'b001, 4'b0000};
      else               e = {2'b00, 1'b0, br | ~haz, br, br | haz, 1'b0};
      e[0] = tmo;
      exp_q.push_back(e);
      @(negedge clk);
      got = obs_vec();
      check_val((c == 0) ? "issue" : ((c <= len) ? "wait" : "advance"), 32'(got), 32'(exp_q.pop_front()));
      finish_cycle();
      mdl_stall_cyc += (c <= len) ? 1 : 0;
      if ((c == len + 1) && (br || haz)) mdl_bubbles++;
    end
    if (len >= WAIT_LIMIT) sticky_tmo = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.ex_mem_memread  = 3'd0;
    bus.ex_mem_memwrite = 3'd0;
    bus.id_ex_memread   = 3'd0;
    bus.id_ex_rd        = 5'd0;
    bus.if_id_rs1       = 5'd0;
    bus.if_id_rs2       = 5'd0;
    bus.branch_taken    = 1'b0;
    bus.im_done         = 1'b0;
    bus.dm_done         = 1'b0;
    #1;
    reset_cycle("reset0");
    reset_cycle("reset1");
    rst = 1'b0;

    // No mem op, fetch done in first wait cycle: advance at c2, re-issue at c3.
    do_step(1'b0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, -1);
    // Load in MEM, im_done at wait+1, dm_done at wait+5: advance at c7.
    do_step(1'b1, 1, 5, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, -1);
    // Load-use on rs2.
    do_step(1'b0, 0, 0, 3'b010, 5'd5, 5'd0, 5'd5, 1'b0, -1);
    // Same with rd = x0: no hazard.
    do_step(1'b0, 0, 0, 3'b010, 5'd0, 5'd0, 5'd0, 1'b0, -1);
    // Branch wins over load-use.
    do_step(1'b1, 0, 0, 3'b010, 5'd5, 5'd5, 5'd9, 1'b1, -1);
    // Withheld dm_done: timeout after 4 wait cycles, stays after the late done.
    do_step(1'b1, 0, 7, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, -1);
    do_step(1'b0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, -1);
    // Reset while dm is pending; next step must re-issue with timeout cleared.
    do_step(1'b1, 0, 6, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2);
    do_step(1'b0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, -1);

    // Randomized steps.
    for (int i = 0; i < 200; i++) begin
      bit         mem;
      int         di;
      int         dd;
      int         len;
      int         ra;
      mem = 1'($urandom_range(0, 1));
      di  = $urandom_range(0, 2);
      dd  = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      len = ((mem && (dd > di)) ? dd : di) + 1;
      ra  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, len - 1) : -1;
      do_step(mem, di, dd, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), ra);
    end

    check_val("fsm_states_visited", 32'($countones(seen_states)), 32'd3);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
